// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer in front of the single data-memory port.
// Each transaction is accept -> ACCESS (memory strobe) -> RESP (one-cycle response pulse).

module dmem_arb_classify #(
  parameter int          MEM_BYTES = 131072,
  parameter logic [31:0] MMIO_ADDR = 32'hFFFF0000
) (
  input  logic [31:0] addr_i,
  output logic        is_mmio_o,
  output logic        is_err_o
);
  localparam logic [31:0] MAX_WORD = 32'(MEM_BYTES - 4);

  assign is_mmio_o = (addr_i == MMIO_ADDR);
  assign is_err_o  = !is_mmio_o && ((addr_i[1:0] != 2'b00) || (addr_i > MAX_WORD));
endmodule

module dmem_arbiter #(
  parameter int          MEM_BYTES = 131072,
  parameter logic [31:0] MMIO_ADDR = 32'hFFFF0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rsp_valid,
  output logic [31:0] p0_rsp_rdata,
  output logic        p0_rsp_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rsp_valid,
  output logic [31:0] p1_rsp_rdata,
  output logic        p1_rsp_err,
  output logic        mem_write,
  output logic        mem_read,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic        busy
);
  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  typedef enum logic [1:0] {CLS_OK, CLS_MMIO, CLS_ERR} cls_e;

  typedef struct packed {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    cls_e        cls;
  } txn_t;

  state_e state_q, state_d;
  txn_t   txn_q, txn_d;
  logic   last_q, last_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [NUM_PORTS-1:0]       req, we, mmio, err;
  logic [NUM_PORTS-1:0][31:0] addr, wdata;
  logic [NUM_PORTS-1:0]       gnt, rsp_v;
  logic [NUM_PORTS-1:0][31:0] rsp_rd;
  logic [NUM_PORTS-1:0]       rsp_e;

  assign req   = {p1_req, p0_req};
  assign we    = {p1_we, p0_we};
  assign addr  = {p1_addr, p0_addr};
  assign wdata = {p1_wdata, p0_wdata};

  genvar g;
  generate
    for (g = 0; g < NUM_PORTS; g++) begin : g_port
      dmem_arb_classify #(.MEM_BYTES(MEM_BYTES), .MMIO_ADDR(MMIO_ADDR)) u_cls (
        .addr_i   (addr[g]),
        .is_mmio_o(mmio[g]),
        .is_err_o (err[g])
      );
      assign rsp_v[g]  = !reset && (state_q == RESP) && (txn_q.port == 1'(g));
      assign rsp_rd[g] = rsp_v[g] ? rdata_q : 32'h0;
      assign rsp_e[g]  = rsp_v[g] && err_q;
    end
  endgenerate

  // Arbitration is open outside ACCESS; on a tie the port not granted last wins.
  logic open_w, win, accept;
  assign open_w = !reset && (state_q != ACCESS);
  assign win    = (req[0] && req[1]) ? ~last_q : req[1];
  assign accept = open_w && (|req);
  assign gnt    = {accept && win, accept && !win};

  always_comb begin
    state_d = state_q;
    txn_d   = txn_q;
    last_d  = last_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (accept) begin
      txn_d.port  = win;
      txn_d.we    = we[win];
      txn_d.addr  = addr[win];
      txn_d.wdata = wdata[win];
      txn_d.cls   = mmio[win] ? CLS_MMIO : (err[win] ? CLS_ERR : CLS_OK);
      last_d      = win;
    end
    case (state_q)
      IDLE:   if (accept) state_d = ACCESS;
      ACCESS: begin
        state_d = RESP;
        rdata_d = (txn_q.cls == CLS_OK && !txn_q.we) ? mem_read_data : 32'h0;
        err_d   = (txn_q.cls == CLS_ERR);
      end
      RESP:   state_d = accept ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      txn_q   <= '{port: 1'b0, we: 1'b0, addr: 32'h0, wdata: 32'h0, cls: CLS_OK};
      last_q  <= 1'b1;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      txn_q   <= txn_d;
      last_q  <= last_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Every output is forced low while reset is high so an in-flight write never commits.
  logic in_access;
  assign in_access      = !reset && (state_q == ACCESS);
  assign mem_read       = in_access && (txn_q.cls == CLS_OK) && !txn_q.we;
  assign mem_write      = in_access && (txn_q.cls != CLS_ERR) && txn_q.we;
  assign mem_address    = in_access ? txn_q.addr : 32'h0;
  assign mem_write_data = in_access ? txn_q.wdata : 32'h0;
  assign busy           = !reset && (state_q != IDLE);

  assign p0_gnt       = gnt[0];
  assign p1_gnt       = gnt[1];
  assign p0_rsp_valid = rsp_v[0];
  assign p1_rsp_valid = rsp_v[1];
  assign p0_rsp_rdata = rsp_rd[0];
  assign p1_rsp_rdata = rsp_rd[1];
  assign p0_rsp_err   = rsp_e[0];
  assign p1_rsp_err   = rsp_e[1];
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a vector table of single transactions plus
// hand-written sequences for round-robin, reset-in-ACCESS and withdrawn requests.

module tb_dmem_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic p0_gnt, p0_rsp_valid, p0_rsp_err, p1_gnt, p1_rsp_valid, p1_rsp_err;
  logic [31:0] p0_rsp_rdata, p1_rsp_rdata;
  logic mem_write, mem_read, busy;
  logic [31:0] mem_address, mem_write_data, mem_read_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata), .p0_rsp_err(p0_rsp_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata), .p1_rsp_err(p1_rsp_err),
    .mem_write(mem_write), .mem_read(mem_read), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data), .busy(busy)
  );

  // Backing memory; every word preloaded with A500_0000 | word index so leaked reads show up.
  logic [31:0] mem [0:32767];
  initial for (int i = 0; i < 32768; i++) mem[i] = 32'hA5000000 | 32'(i);
  always @(posedge clk) if (mem_write && mem_address < 32'd131072) mem[mem_address[16:2]] <= mem_write_data;
  assign mem_read_data = mem[mem_address[16:2]];

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
    bit          exp_wr;
    bit          exp_rd;
  } vec_t;
  vec_t vecs[11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic set_req(input bit port, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    if (port) begin p1_req = r; p1_we = w; p1_addr = a; p1_wdata = d; end
    else      begin p0_req = r; p0_we = w; p0_addr = a; p0_wdata = d; end
  endtask

  task automatic chk_idle_outs(input string nm);
    chk({nm, " gnt"}, {30'h0, p1_gnt, p0_gnt}, 32'h0);
    chk({nm, " rsp_valid"}, {30'h0, p1_rsp_valid, p0_rsp_valid}, 32'h0);
    chk({nm, " rdata0"}, p0_rsp_rdata, 32'h0);
    chk({nm, " rdata1"}, p1_rsp_rdata, 32'h0);
    chk({nm, " err"}, {30'h0, p1_rsp_err, p0_rsp_err}, 32'h0);
    chk({nm, " strobes"}, {30'h0, mem_write, mem_read}, 32'h0);
    chk({nm, " mem_address"}, mem_address, 32'h0);
    chk({nm, " mem_write_data"}, mem_write_data, 32'h0);
    chk({nm, " busy"}, {31'h0, busy}, 32'h0);
  endtask

  // One transaction from an idle arbiter: accept, ACCESS, RESP.
  task automatic do_txn(input vec_t v, input string nm);
    logic [1:0] one;
    one = v.port ? 2'b10 : 2'b01;
    @(negedge clk);
    set_req(v.port, 1'b1, v.we, v.addr, v.wdata);
    #1;
    chk({nm, " gnt"}, {30'h0, p1_gnt, p0_gnt}, {30'h0, one});
    @(negedge clk);
    #1;
    chk({nm, " no gnt in ACCESS"}, {30'h0, p1_gnt, p0_gnt}, 32'h0);
    chk({nm, " mem_write"}, {31'h0, mem_write}, {31'h0, v.exp_wr});
    chk({nm, " mem_read"}, {31'h0, mem_read}, {31'h0, v.exp_rd});
    chk({nm, " mem_address"}, mem_address, v.addr);
    chk({nm, " mem_write_data"}, mem_write_data, v.wdata);
    chk({nm, " busy"}, {31'h0, busy}, 32'h1);
    set_req(v.port, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    #1;
    chk({nm, " rsp_valid"}, {30'h0, p1_rsp_valid, p0_rsp_valid}, {30'h0, one});
    chk({nm, " rdata"}, v.port ? p1_rsp_rdata : p0_rsp_rdata, v.exp_rdata);
    chk({nm, " err"}, {31'h0, v.port ? p1_rsp_err : p0_rsp_err}, {31'h0, v.exp_err});
    chk({nm, " strobes in RESP"}, {30'h0, mem_write, mem_read}, 32'h0);
  endtask

  initial begin
    vecs[0]  = '{0, 1, 32'h00000100, 32'hDEADBEEF, 32'h0,        0, 1, 0};
    vecs[1]  = '{0, 0, 32'h00000100, 32'h0,        32'hDEADBEEF, 0, 0, 1};
    vecs[2]  = '{1, 0, 32'h00000102, 32'h0,        32'h0,        1, 0, 0};
    vecs[3]  = '{1, 0, 32'h00020000, 32'h0,        32'h0,        1, 0, 0};
    vecs[4]  = '{1, 0, 32'h0001FFFC, 32'h0,        32'hA5007FFF, 0, 0, 1};
    vecs[5]  = '{0, 1, 32'hFFFF0000, 32'd42,       32'h0,        0, 1, 0};
    vecs[6]  = '{0, 0, 32'hFFFF0000, 32'h0,        32'h0,        0, 0, 0};
    vecs[7]  = '{1, 0, 32'hFFFF0004, 32'h0,        32'h0,        1, 0, 0};
    vecs[8]  = '{1, 1, 32'h0001FFFD, 32'h12345678, 32'h0,        1, 0, 0};
    vecs[9]  = '{0, 1, 32'h00000040, 32'h11111111, 32'h0,        0, 1, 0};
    vecs[10] = '{1, 0, 32'h00000040, 32'h0,        32'h11111111, 0, 0, 1};

    reset = 1'b1;
    set_req(0, 1'b1, 1'b1, 32'h100, 32'h5);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk_idle_outs("reset");
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

    // Round-robin: both ports hold reads from a fresh reset; expect p0,p1,p0,p1 every other cycle.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    set_req(0, 1'b1, 1'b0, 32'h100, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h040, 32'h0);
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 8) begin
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
      end
      #1;
      chk($sformatf("rr c%0d gnt", c), {30'h0, p1_gnt, p0_gnt},
          (c == 8) ? 32'h0 : (c % 4 == 0) ? 32'h1 : (c % 4 == 2) ? 32'h2 : 32'h0);
      chk($sformatf("rr c%0d rsp_valid", c), {30'h0, p1_rsp_valid, p0_rsp_valid},
          (c % 4 == 2) ? 32'h1 : (c > 0 && c % 4 == 0) ? 32'h2 : 32'h0);
      if (c % 4 == 2) chk($sformatf("rr c%0d rdata0", c), p0_rsp_rdata, 32'hDEADBEEF);
      if (c > 0 && c % 4 == 0) chk($sformatf("rr c%0d rdata1", c), p1_rsp_rdata, 32'h11111111);
      if (c % 2 == 1) chk($sformatf("rr c%0d mem_read", c), {31'h0, mem_read}, 32'h1);
    end

    // Reset in the ACCESS cycle of a write: dropped, not committed.
    @(negedge clk);
    set_req(0, 1'b1, 1'b1, 32'h40, 32'h22222222);
    #1;
    chk("rst-access gnt", {31'h0, p0_gnt}, 32'h1);
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    #1;
    chk("rst-access mem_write", {31'h0, mem_write}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk_idle_outs("rst-after");
    do_txn('{0, 0, 32'h40, 32'h0, 32'h11111111, 0, 0, 1}, "rst-readback");

    // p0 withdraws its request while p1 is in ACCESS: never granted, never answered.
    @(negedge clk);
    set_req(1, 1'b1, 1'b0, 32'h1FFFC, 32'h0);
    #1;
    chk("wd p1 gnt", {30'h0, p1_gnt, p0_gnt}, 32'h2);
    @(negedge clk);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(0, 1'b1, 1'b0, 32'h100, 32'h0);
    #1;
    chk("wd access gnt", {30'h0, p1_gnt, p0_gnt}, 32'h0);
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    #1;
    chk("wd resp valid", {30'h0, p1_rsp_valid, p0_rsp_valid}, 32'h2);
    chk("wd resp rdata", p1_rsp_rdata, 32'hA5007FFF);
    chk("wd resp gnt", {30'h0, p1_gnt, p0_gnt}, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      chk_idle_outs($sformatf("wd after%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the 128 KB byte-addressed data memory. It lets the CPU load/store path (port 0) and a loader/DMA requester (port 1) share the single memory port. It uses round-robin arbitration, a request/grant handshake and a registered single-beat response. It also performs alignment and range checking, and routes the 0xFFFF0000 print-MMIO write through to the memory unchanged.

## Interface
- MEM_BYTES, 131072: size of backing memory in bytes; valid word addresses are 0..MEM_BYTES-4.
- MMIO_ADDR, 32'hFFFF0000: output-device address; writes pass to memory port, reads return 0.
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- pN_req  in  1  (N=0,1) request valid; held with pN_we/pN_addr/pN_wdata stable until granted.
- pN_we  in  1  1 = word write, 0 = word read.
- pN_addr  in  32  byte address.
- pN_wdata  in  32  write data.
- pN_gnt  out  1  request accepted at this rising edge (when pN_req=1).
- pN_rsp_valid  out  1  one-cycle response pulse.
- pN_rsp_rdata  out  32  read data (0 for writes, errors, MMIO reads).
- pN_rsp_err  out  1  access rejected (misaligned or out of range).
- mem_write  out  1  to memory MemWrite.
- mem_read  out  1  to memory MemRead.
- mem_address  out  32  to memory address.
- mem_write_data  out  32  to memory writeData.
- mem_read_data  in  32  from memory readData (combinational w.r.t. address/MemRead).
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, ACCESS, RESP. Reset -> IDLE.
- Arbitration is open in IDLE and RESP.
  - pN_gnt is combinational: asserted for the winner when its req=1.
  - Both requesting: the port not granted last wins (round-robin).
  - last_grant resets to 1, so port 0 wins the first tie.
  - A single requester always wins.
- On an accepted edge:
  - Latch port id, we, addr and wdata.
  - Classify the request as OK, MMIO or ERR.
  - Go to ACCESS and update last_grant.
- Classification:
  - MMIO: addr == MMIO_ADDR.
  - ERR: not MMIO, and either addr[1:0] != 0 or addr > MEM_BYTES-4.
  - OK: otherwise.
- ACCESS (exactly one cycle):
  - mem_address = latched addr and mem_write_data = latched wdata in all classes.
  - OK read: mem_read=1. Capture mem_read_data into the response register at the edge.
  - OK write: mem_write=1.
  - MMIO write: mem_write=1.
  - MMIO read: no strobe; rdata=0.
  - ERR: no strobe; err=1, rdata=0.
  - Always go to RESP.
- RESP:
  - Assert rsp_valid only for the latched port, for one cycle, with rdata/err.
  - If there is a new accept this cycle, go to ACCESS; else go to IDLE.
- Outside ACCESS: mem_write=mem_read=0, mem_address=0, mem_write_data=0.
- mem_write and mem_read are gated by !reset, so no memory write commits on a reset edge.

## Timing
- Accept at the edge ending cycle N -> ACCESS in N+1 -> rsp_valid in N+2.
- Back-to-back throughput: one transaction per 2 cycles (accept during RESP).
- Reset values:
  - All outputs 0: gnt, rsp_valid, rsp_rdata, rsp_err, mem_*, busy.
  - State = IDLE, last_grant=1.
- Reset during ACCESS or RESP:
  - The transaction is dropped and no response is issued.
  - A write in ACCESS does not commit.
  - No gnt is asserted while reset=1.
- pN_gnt is never asserted in ACCESS; requests wait.
- An unchanged held request is re-arbitrated each open cycle.
- Only one of p0_gnt/p1_gnt is high in any cycle; likewise only one rsp_valid.
- A request deasserted before grant is never serviced; no state is retained for it.
- Address boundaries:
  - MEM_BYTES-4 is OK.
  - MEM_BYTES-3 is ERR (misaligned).
  - MEM_BYTES is ERR (range).
  - 0xFFFF0000 is MMIO; 0xFFFF0004 is ERR.

## Test plan
- Port 0 write 0xDEADBEEF @0x100, then read @0x100 -> mem_write=1 in ACCESS cycle; read rsp_valid 2 cycles after gnt, rdata=0xDEADBEEF, err=0.
- Both ports request reads every cycle after reset -> grants alternate p0,p1,p0,p1; one grant per 2 cycles; each rsp_valid only on the granted port.
- p1 read @0x102 and @0x20000 -> err=1, rdata=0, mem_read/mem_write stay 0 for both; @0x1FFFC -> err=0.
- p0 write 42 @0xFFFF0000 -> mem_write=1 with mem_address=0xFFFF0000, mem_write_data=42; MMIO read -> rdata=0, err=0, mem_read=0.
- Write 0x11111111 @0x40; then a write of 0x22222222 @0x40 with reset asserted in its ACCESS cycle -> no rsp_valid, outputs 0 next cycle; a later read @0x40 returns 0x11111111.
- p0 request deasserted while p1 is in ACCESS -> p0 is never granted and gets no response; p1 completes normally.
